// File: rtl/tdc_channel_scheduler.sv
// ============================================================================
// Module  : tdc_channel_scheduler
// Purpose : Time-shares one event counter across NUM_CH TDC channels, one
//           fixed count window per enabled channel, results on valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_channel_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int CH_BITS      = 2,
  parameter int WINDOW_BITS  = 10,
  parameter int COUNTER_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [NUM_CH-1:0]       ch_mask_i,
  input  logic [COUNTER_BITS-1:0] count_in_i,
  output logic [CH_BITS-1:0]      sel_o,
  output logic                    cnt_clear_o,
  output logic                    cnt_en_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [COUNTER_BITS-1:0] res_data_o,
  output logic [CH_BITS-1:0]      res_ch_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESULT  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [CH_BITS-1:0]      sel_q, sel_d;
  logic [WINDOW_BITS-1:0]  win_q, win_d;
  logic                    res_valid_q, res_valid_d;
  logic [COUNTER_BITS-1:0] res_data_q, res_data_d;
  logic [CH_BITS-1:0]      res_ch_q, res_ch_d;
  logic                    zdone_q, zdone_d;

  logic                    first_found, next_found;
  logic [CH_BITS-1:0]      first_ch, next_ch;

  // Descending scans so the last hit written is the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) begin
        first_found = 1'b1;
        first_ch    = CH_BITS'(i);
      end
      if (mask_q[i] && (CH_BITS'(i) > sel_q)) begin
        next_found = 1'b1;
        next_ch    = CH_BITS'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    win_d       = win_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    zdone_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (first_found) begin
            mask_d  = ch_mask_i;
            sel_d   = first_ch;
            state_d = ST_SELECT;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ST_SELECT: begin
        win_d   = '0;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        win_d = win_q + 1'b1;
        if (&win_q) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        res_data_d  = count_in_i;
        res_ch_d    = sel_q;
        res_valid_d = 1'b1;
        state_d     = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          if (next_found) begin
            sel_d   = next_ch;
            state_d = ST_SELECT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      sel_q       <= '0;
      win_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      win_q       <= win_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      zdone_q     <= zdone_d;
    end
  end

  assign sel_o       = sel_q;
  assign cnt_clear_o = (state_q == ST_SELECT);
  assign cnt_en_o    = (state_q == ST_MEASURE);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_ch_o    = res_ch_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) || zdone_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_channel_scheduler.sv
// ============================================================================
// Module  : tb_tdc_channel_scheduler
// Purpose : Directed self-checking bench for tdc_channel_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdc_channel_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 16-cycle window
  logic       start_a, ready_a;
  logic [3:0] mask_a;
  logic [7:0] cnt_a, data_a;
  logic [1:0] sel_a, ch_a;
  logic       clr_a, en_a, valid_a, busy_a, done_a;

  // Instance B: 512-cycle window
  logic       start_b, ready_b;
  logic [3:0] mask_b;
  logic [7:0] cnt_b, data_b;
  logic [1:0] sel_b, ch_b;
  logic       clr_b, en_b, valid_b, busy_b, done_b;

  tdc_channel_scheduler #(.NUM_CH(4), .CH_BITS(2), .WINDOW_BITS(4), .COUNTER_BITS(8)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .ch_mask_i(mask_a), .count_in_i(cnt_a),
    .sel_o(sel_a), .cnt_clear_o(clr_a), .cnt_en_o(en_a), .res_valid_o(valid_a),
    .res_ready_i(ready_a), .res_data_o(data_a), .res_ch_o(ch_a), .busy_o(busy_a), .done_o(done_a)
  );

  tdc_channel_scheduler #(.NUM_CH(4), .CH_BITS(2), .WINDOW_BITS(9), .COUNTER_BITS(8)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .ch_mask_i(mask_b), .count_in_i(cnt_b),
    .sel_o(sel_b), .cnt_clear_o(clr_b), .cnt_en_o(en_b), .res_valid_o(valid_b),
    .res_ready_i(ready_b), .res_data_o(data_b), .res_ch_o(ch_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Shared-counter models: clear wins, otherwise count every enabled cycle.
  always @(posedge clk or posedge rst) begin
    if (rst)        cnt_a <= 8'd0;
    else if (clr_a) cnt_a <= 8'd0;
    else if (en_a)  cnt_a <= cnt_a + 8'd1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst)        cnt_b <= 8'd0;
    else if (clr_b) cnt_b <= 8'd0;
    else if (en_b)  cnt_b <= cnt_b + 8'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observation record for instance A
  int         nres, first_valid_c, ndone, done_c, busy_at_done, busy_after_done, en_cycles;
  logic       any_valid, any_busy;
  logic [1:0] rch [8];
  logic [7:0] rdata [8];

  task automatic observe(input int ncyc);
    nres = 0; first_valid_c = -1; ndone = 0; done_c = -1;
    busy_at_done = -1; busy_after_done = -1; en_cycles = 0;
    any_valid = 1'b0; any_busy = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (valid_a && first_valid_c < 0) first_valid_c = c;
      if (valid_a && ready_a) begin
        if (nres < 8) begin
          rch[nres]   = ch_a;
          rdata[nres] = data_a;
        end
        nres++;
      end
      if (ndone > 0 && done_c == c - 1) busy_after_done = int'(busy_a);
      if (done_a) begin
        ndone++;
        done_c       = c;
        busy_at_done = int'(busy_a);
      end
      if (en_a) en_cycles++;
      any_valid = any_valid | valid_a;
      any_busy  = any_busy | busy_a;
      @(negedge clk);
    end
  endtask

  // Start edge falls between the two negedges; returns on the SELECT cycle.
  task automatic pulse_start_a(input logic [3:0] m);
    mask_a  = m;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  function automatic logic [31:0] outs_a();
    return {15'd0, sel_a, clr_a, en_a, valid_a, data_a, ch_a, busy_a, done_a};
  endfunction

  function automatic logic [31:0] outs_b();
    return {15'd0, sel_b, clr_b, en_b, valid_b, data_b, ch_b, busy_b, done_b};
  endfunction

  initial begin
    int bad;
    int c;
    rst = 1'b1;
    start_a = 1'b0; mask_a = 4'd0; ready_a = 1'b0;
    start_b = 1'b0; mask_b = 4'd0; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a(), 32'd0);
    check("reset_outs_b", outs_b(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: two channels, always ready
    ready_a = 1'b1;
    pulse_start_a(4'b0101);
    check("t1_clear", {31'd0, clr_a}, 32'd1);
    check("t1_sel0", {30'd0, sel_a}, 32'd0);
    observe(45);
    check("t1_nres", nres, 2);
    check("t1_ch0", {30'd0, rch[0]}, 32'd0);
    check("t1_data0", {24'd0, rdata[0]}, 32'd16);
    check("t1_ch1", {30'd0, rch[1]}, 32'd2);
    check("t1_data1", {24'd0, rdata[1]}, 32'd16);
    check("t1_first_valid", first_valid_c, 18);
    check("t1_ndone", ndone, 1);
    check("t1_done_cycle", done_c, 38);
    check("t1_busy_at_done", busy_at_done, 1);
    check("t1_busy_after", busy_after_done, 0);
    check("t1_en_cycles", en_cycles, 32);

    // 2: empty mask
    pulse_start_a(4'b0000);
    observe(6);
    check("t2_ndone", ndone, 1);
    check("t2_done_cycle", done_c, 0);
    check("t2_no_valid", {31'd0, any_valid}, 32'd0);
    check("t2_no_busy", {31'd0, any_busy}, 32'd0);

    // 3: back-pressure for 40 cycles
    ready_a = 1'b0;
    pulse_start_a(4'b1000);
    c = 0;
    while (!valid_a && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t3_valid_cycle", c, 18);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(valid_a && data_a == 8'd16 && ch_a == 2'd3 && sel_a == 2'd3 && !done_a)) bad++;
      @(negedge clk);
    end
    check("t3_hold", bad, 0);
    ready_a = 1'b1;
    @(negedge clk);
    check("t3_done_after_hs", {30'd0, done_a, valid_a}, 32'd2);
    ready_a = 1'b0;
    @(negedge clk);
    check("t3_idle", {30'd0, done_a, busy_a}, 32'd0);

    // 4: start and mask changes during a scan are ignored
    ready_a = 1'b1;
    pulse_start_a(4'b0010);
    repeat (4) @(negedge clk);
    mask_a  = 4'b1111;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    mask_a  = 4'b0000;
    observe(30);
    check("t4_nres", nres, 1);
    check("t4_ch", {30'd0, rch[0]}, 32'd1);
    check("t4_data", {24'd0, rdata[0]}, 32'd16);
    check("t4_ndone", ndone, 1);
    check("t4_idle_end", {31'd0, busy_a}, 32'd0);

    // 5: asynchronous reset mid-window, then a clean scan
    pulse_start_a(4'b0001);
    repeat (5) @(negedge clk);
    check("t5_en_before", {31'd0, en_a}, 32'd1);
    #2 rst = 1'b1;
    #1 check("t5_async_zero", outs_a(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start_a(4'b0001);
    observe(25);
    check("t5_nres", nres, 1);
    check("t5_ch", {30'd0, rch[0]}, 32'd0);
    check("t5_data", {24'd0, rdata[0]}, 32'd16);

    // 6: 512-cycle window wraps an 8-bit counter to zero
    mask_b  = 4'b0001;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    c   = 0;
    bad = 0;
    while (!valid_b && c < 700) begin
      if (en_b) bad++;
      @(negedge clk);
      c++;
    end
    check("t6_valid_cycle", c, 514);
    check("t6_en_cycles", bad, 512);
    check("t6_data", {24'd0, data_b}, 32'd0);
    check("t6_ch", {30'd0, ch_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
